// File: rtl/hazard_scoreboard.sv
// Load-use stall / branch flush detection and forwarding-select generation for a
// 5-stage in-order pipeline, tracking the destinations of the EX, MEM and WB slots.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             ld_use, advance;

    function automatic logic hit(slot_t s, logic [4:0] r, logic used);
        return used && (r != 5'd0) && s.valid && s.wr_en && (s.wr_reg == r);
    endfunction

    // Youngest producer wins; a load in EX cannot forward (that case stalls instead).
    function automatic logic [1:0] sel(slot_t ex, slot_t mem, slot_t wb,
                                       logic [4:0] r, logic used);
        if (hit(ex, r, used) && !ex.is_load) return 2'd1;
        else if (hit(mem, r, used))          return 2'd2;
        else if (hit(wb, r, used))           return 2'd3;
        else                                 return 2'd0;
    endfunction

    always_comb begin
        flush   = ex_branch_taken;
        ld_use  = id_valid && ex_q.is_load &&
                  (hit(ex_q, id_rs, id_uses_rs) || hit(ex_q, id_rt, id_uses_rt));
        stall   = ld_use && !flush;
        advance = id_valid && !stall && !flush;

        ex_d = '0;
        if (advance) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_wr_en;
            ex_d.wr_reg  = id_wr_reg;
            ex_d.is_load = id_is_load;
        end

        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
        if (advance) begin
            fwd_a_d = sel(ex_q, mem_q, wb_q, id_rs, id_uses_rs);
            fwd_b_d = sel(ex_q, mem_q, wb_q, id_rt, id_uses_rt);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= 2'd0;
            fwd_b_q     <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
